// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the instruction micro-sequencer: state encoding,
// default sizes and the micro-op strobe index constants.
package cpu_seq_pkg;

    localparam int MAX_UOPS_DEF      = 3;
    localparam int COUNT_W_DEF       = 32;
    localparam int FETCH_TIMEOUT_DEF = 16;

    // Bit positions inside select_strobe / load_strobe, shared with the
    // selector and alu_result_selector blocks.
    localparam int UOP_SEL1 = 0;
    localparam int UOP_SEL2 = 1;
    localparam int UOP_SEL3 = 2;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_SEL     = 3'd2,
        S_LOAD    = 3'd3,
        S_EIP_ADV = 3'd4,
        S_HALTED  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Signal bundle between the micro-sequencer and the datapath it drives.
interface micro_sequencer_if
    import cpu_seq_pkg::*;
#(
    parameter int MAX_UOPS = MAX_UOPS_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) ();
    // Fetch handshake: fetch_strobe acts as valid and mem_ready as ready; a
    // fetch completes on a rising edge where both are high, and fetch_strobe
    // stays high for as long as mem_ready is low.
    logic [3:0]          num_of_ope;
    logic                mem_ready;
    logic                halt_req;
    logic                fetch_strobe;
    logic                decode_strobe;
    logic [MAX_UOPS-1:0] select_strobe;
    logic [MAX_UOPS-1:0] load_strobe;
    logic                eip_strobe;
    logic [1:0]          uop_index;
    logic                busy;
    logic                halted;
    logic [COUNT_W-1:0]  instr_count;
    logic                err_bad_len;
    logic                err_timeout;
    seq_state_t          dbg_state;

    modport master (
        output num_of_ope, mem_ready, halt_req,
        input  fetch_strobe, decode_strobe, select_strobe, load_strobe,
        input  eip_strobe, uop_index, busy, halted, instr_count,
        input  err_bad_len, err_timeout, dbg_state
    );

    modport slave (
        input  num_of_ope, mem_ready, halt_req,
        output fetch_strobe, decode_strobe, select_strobe, load_strobe,
        output eip_strobe, uop_index, busy, halted, instr_count,
        output err_bad_len, err_timeout, dbg_state
    );

endinterface

// File: rtl/micro_sequencer_watchdog.sv
// Counts consecutive stalled fetch cycles and pulses timeout on the cycle
// that would make the count reach FETCH_TIMEOUT.
module fetch_watchdog #(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);
    localparam int CW = $clog2(FETCH_TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = count_en && !clear && (count == CW'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/micro_sequencer.sv
// Variable-length control sequencer: fetch, decode, 1..MAX_UOPS select/load
// pairs, then EIP advance. All strobes are registered and mutually exclusive.
module micro_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MAX_UOPS      = MAX_UOPS_DEF,
    parameter int COUNT_W       = COUNT_W_DEF,
    parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    micro_sequencer_if.slave bus
);
    localparam logic [3:0]          MAX_LEN = 4'(MAX_UOPS);
    localparam logic [MAX_UOPS-1:0] UOP_ONE = MAX_UOPS'(1);

    seq_state_t          state, state_n;
    logic [1:0]          uop_index, uop_n;
    logic [3:0]          len_q, len_n;
    logic                halt_pending, bad_len;
    logic                wd_clear, wd_en, wd_timeout;
    logic                fetch_q, decode_q, eip_q, busy_q, halted_q;
    logic                err_bad_len_q, err_timeout_q;
    logic [MAX_UOPS-1:0] select_q, load_q;
    logic [COUNT_W-1:0]  instr_count_q;

    // fetch_q is zero while in reset, so the first FETCH cycle after release
    // always shows the strobe before a fetch can be accepted.
    assign wd_en    = fetch_q && !bus.mem_ready;
    assign wd_clear = fetch_q && bus.mem_ready;

    fetch_watchdog #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .count_en (wd_en),
        .timeout  (wd_timeout)
    );

    always_comb begin
        state_n = state;
        uop_n   = uop_index;
        len_n   = len_q;
        bad_len = 1'b0;
        case (state)
            S_FETCH: begin
                if (wd_timeout)    state_n = S_HALTED;
                else if (wd_clear) state_n = S_DECODE;
            end
            S_DECODE: begin
                state_n = S_SEL;
                uop_n   = 2'(UOP_SEL1);
            end
            S_SEL: begin
                state_n = S_LOAD;
                if (uop_index == 2'(UOP_SEL1)) begin
                    if (bus.num_of_ope == 4'd0) begin
                        bad_len = 1'b1;
                        len_n   = 4'd0;
                        state_n = S_EIP_ADV;
                    end else if (bus.num_of_ope > MAX_LEN) begin
                        bad_len = 1'b1;
                        len_n   = MAX_LEN;
                    end else begin
                        len_n   = bus.num_of_ope;
                    end
                end
            end
            S_LOAD: begin
                if (({2'b00, uop_index} + 4'd1) < len_q) begin
                    uop_n   = uop_index + 2'd1;
                    state_n = S_SEL;
                end else begin
                    state_n = S_EIP_ADV;
                end
            end
            S_EIP_ADV: begin
                if (halt_pending || bus.halt_req) begin
                    state_n = S_HALTED;
                end else begin
                    state_n = S_FETCH;
                    uop_n   = 2'(UOP_SEL1);
                end
            end
            S_HALTED: state_n = S_HALTED;
            default:  state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_FETCH;
            uop_index     <= '0;
            len_q         <= '0;
            halt_pending  <= 1'b0;
            err_bad_len_q <= 1'b0;
            err_timeout_q <= 1'b0;
            fetch_q       <= 1'b0;
            decode_q      <= 1'b0;
            select_q      <= '0;
            load_q        <= '0;
            eip_q         <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state         <= state_n;
            uop_index     <= uop_n;
            len_q         <= len_n;
            halt_pending  <= halt_pending | bus.halt_req;
            err_bad_len_q <= err_bad_len_q | bad_len;
            err_timeout_q <= err_timeout_q | wd_timeout;
            fetch_q       <= (state_n == S_FETCH);
            decode_q      <= (state_n == S_DECODE);
            select_q      <= (state_n == S_SEL)  ? (UOP_ONE << uop_n) : '0;
            load_q        <= (state_n == S_LOAD) ? (UOP_ONE << uop_n) : '0;
            eip_q         <= (state_n == S_EIP_ADV);
            busy_q        <= (state_n != S_HALTED);
            halted_q      <= (state_n == S_HALTED);
            instr_count_q <= instr_count_q + COUNT_W'(state_n == S_EIP_ADV);
        end
    end

    assign bus.fetch_strobe  = fetch_q;
    assign bus.decode_strobe = decode_q;
    assign bus.select_strobe = select_q;
    assign bus.load_strobe   = load_q;
    assign bus.eip_strobe    = eip_q;
    assign bus.uop_index     = uop_index;
    assign bus.busy          = busy_q;
    assign bus.halted        = halted_q;
    assign bus.instr_count   = instr_count_q;
    assign bus.err_bad_len   = err_bad_len_q;
    assign bus.err_timeout   = err_timeout_q;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: cycle-exact strobe sequences, bad
// lengths, fetch stall and timeout, halt request and asynchronous reset.
module tb_micro_sequencer;
    import cpu_seq_pkg::*;

    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] F    = 9'h100;
    localparam logic [8:0] D    = 9'h080;
    localparam logic [8:0] S0   = 9'h010;
    localparam logic [8:0] L0   = 9'h002;
    localparam logic [8:0] E    = 9'h001;

    logic clk;
    logic reset;
    int   tests     = 0;
    int   fails     = 0;
    int   onehot_err = 0;
    int   load2_cnt = 0;
    int   base;

    micro_sequencer_if #(.MAX_UOPS(3), .COUNT_W(32)) bus ();

    micro_sequencer #(.MAX_UOPS(3), .COUNT_W(32), .FETCH_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe monitor: exclusivity and load_strobe[2] occurrences
    always @(negedge clk) begin
        if ($countones({bus.fetch_strobe, bus.decode_strobe, bus.select_strobe,
                        bus.load_strobe, bus.eip_strobe}) > 1)
            onehot_err++;
        if (bus.load_strobe[2])
            load2_cnt++;
    end

    function automatic logic [8:0] strobes();
        return {bus.fetch_strobe, bus.decode_strobe, bus.select_strobe,
                bus.load_strobe, bus.eip_strobe};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.halt_req  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
    endtask

    // Starts on a cycle expected to be the first FETCH of an instruction and
    // returns on the cycle after its EIP strobe.
    task automatic run_instr(input int num, input int stall, input bit halt_pulse,
                             input string tag);
        int n;
        n = (num > 3) ? 3 : num;
        bus.num_of_ope = 4'(num);
        if (stall > 0) bus.mem_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall"}, 64'(strobes()), 64'(F));
            step();
        end
        bus.mem_ready = 1'b1;
        check({tag, "_fetch"}, 64'(strobes()), 64'(F));
        step();
        check({tag, "_decode"}, 64'(strobes()), 64'(D));
        step();
        check({tag, "_sel0"}, 64'(strobes()), 64'(S0));
        step();
        bus.num_of_ope = 4'($urandom_range(0, 15));
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                check({tag, "_sel"}, 64'(strobes()), 64'(S0 << k));
                check({tag, "_uop_index"}, 64'(bus.uop_index), 64'(k));
                step();
            end
            check({tag, "_load"}, 64'(strobes()), 64'(L0 << k));
            if (halt_pulse && k == 0) bus.halt_req = 1'b1;
            step();
            bus.halt_req = 1'b0;
        end
        check({tag, "_eip"}, 64'(strobes()), 64'(E));
        step();
    endtask

    initial begin
        reset          = 1'b1;
        bus.mem_ready  = 1'b1;
        bus.halt_req   = 1'b0;
        bus.num_of_ope = 4'd2;
        @(posedge clk);
        #1;
        check("rst_strobes", 64'(strobes()), 64'(NONE));
        check("rst_count", 64'(bus.instr_count), 64'd0);
        check("rst_busy_halted", 64'({bus.busy, bus.halted}), 64'd0);
        check("rst_errs", 64'({bus.err_bad_len, bus.err_timeout}), 64'd0);
        check("rst_uop", 64'(bus.uop_index), 64'd0);
        reset = 1'b0;
        step();

        // two-uop instruction from reset release: 7 cycles, then FETCH
        run_instr(2, 0, 1'b0, "t1");
        check("t1_next_fetch", 64'(strobes()), 64'(F));
        check("t1_count", 64'(bus.instr_count), 64'd1);
        check("t1_busy", 64'(bus.busy), 64'd1);

        // lengths 1,3,1
        base = load2_cnt;
        run_instr(1, 0, 1'b0, "t2a");
        run_instr(3, 0, 1'b0, "t2b");
        run_instr(1, 0, 1'b0, "t2c");
        check("t2_count", 64'(bus.instr_count), 64'd4);
        check("t2_load2_once", 64'(load2_cnt - base), 64'd1);
        check("t2_no_bad_len", 64'(bus.err_bad_len), 64'd0);

        // oversize length clamps to three loads
        run_instr(7, 0, 1'b0, "t3_len7");
        check("t3_len7_bad", 64'(bus.err_bad_len), 64'd1);
        check("t3_len7_count", 64'(bus.instr_count), 64'd5);

        // zero length: SEL then EIP, no load
        do_reset();
        check("t3_rst_bad_clear", 64'(bus.err_bad_len), 64'd0);
        run_instr(0, 0, 1'b0, "t3_len0");
        check("t3_len0_bad", 64'(bus.err_bad_len), 64'd1);
        check("t3_len0_count", 64'(bus.instr_count), 64'd1);

        // five stalled fetch cycles then normal progress
        run_instr(2, 5, 1'b0, "t4_stall");
        check("t4_count", 64'(bus.instr_count), 64'd2);
        check("t4_no_timeout", 64'(bus.err_timeout), 64'd0);

        // stuck mem_ready: 16 fetch cycles then HALTED
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("t4_to_fetch", 64'(strobes()), 64'(F));
            step();
        end
        check("t4_to_err", 64'(bus.err_timeout), 64'd1);
        check("t4_to_halted", 64'({bus.halted, bus.busy}), 64'h2);
        check("t4_to_strobes", 64'(strobes()), 64'(NONE));
        check("t4_to_count", 64'(bus.instr_count), 64'd2);

        // halt pulse during first LOAD of a 3-uop instruction
        do_reset();
        run_instr(3, 0, 1'b1, "t5");
        check("t5_halted", 64'({bus.halted, bus.busy}), 64'h2);
        check("t5_count", 64'(bus.instr_count), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("t5_quiet", 64'(strobes()), 64'(NONE));
            step();
        end

        // asynchronous reset in the middle of SEL
        do_reset();
        run_instr(1, 0, 1'b0, "t6_pre");
        bus.num_of_ope = 4'd3;
        check("t6_fetch", 64'(strobes()), 64'(F));
        step();
        check("t6_decode", 64'(strobes()), 64'(D));
        step();
        check("t6_sel0", 64'(strobes()), 64'(S0));
        step();
        check("t6_load0", 64'(strobes()), 64'(L0));
        step();
        check("t6_sel1", 64'(strobes()), 64'(S0 << 1));
        check("t6_count_pre", 64'(bus.instr_count), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_strobes", 64'(strobes()), 64'(NONE));
        check("t6_async_count", 64'(bus.instr_count), 64'd0);
        check("t6_async_uop", 64'(bus.uop_index), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("t6_first_fetch", 64'(strobes()), 64'(F));
        check("t6_count_post", 64'(bus.instr_count), 64'd0);

        check("strobe_onehot", 64'(onehot_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
